pwm_demodulator: RTL and testbench

- Receive-side counterpart of the waveform generator's PWM converter output.
- Takes the 1-bit PWM stream, recovers frame alignment and measures the high time per frame, rebuilding the 8-bit sample stream that drove the converter.
- Sits after the pwm_converter_out pin, either in loopback inside top or on a second board. Its output feeds a compare/scope path for checking amplitude_sel and wave_sel settings.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_in_sync.sv | 29 ++
 rtl/pwm_demodulator.sv | 103 ++++++++++
 tb/tb_pwm_demodulator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM constants and demodulator state encoding, common to the
// converter (transmit) and demodulator (receive) sides.
package pwm_pkg;

  localparam int PWM_WIDTH  = 8;
  localparam int PWM_PERIOD = 1 << PWM_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HUNT    = 2'd1,
    S_MEASURE = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Multi-flop synchronizer for the asynchronous PWM pin plus a rising-edge
// detect on the synchronized level.
module pwm_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_i,
  output logic pwm_s_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              pwm_s_d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      pwm_s_d_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[STAGES-2:0], pwm_i};
      pwm_s_d_q <= sync_q[STAGES-1];
    end
  end

  assign pwm_s_o = sync_q[STAGES-1];
  assign rise_o  = pwm_s_o & ~pwm_s_d_q;

endmodule

// File: rtl/pwm_demodulator.sv
// Recovers WIDTH-bit samples from a PWM stream: locks to the frame start
// on a rising edge, then counts high cycles over each 2**WIDTH-clock frame.
module pwm_demodulator
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             locked,
  output logic             frame_err
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic             pwm_s, rise;
  pwm_state_e       state_q;
  logic [WIDTH-1:0] frame_cnt_q;
  logic [WIDTH:0]   high_cnt_q;
  logic [WIDTH:0]   high_sum;
  logic [WIDTH-1:0] sample_q;
  logic             valid_q, locked_q, err_q;

  pwm_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .pwm_i   (pwm_in),
    .pwm_s_o (pwm_s),
    .rise_o  (rise)
  );

  // High count including the current cycle; bit WIDTH set means every
  // cycle of the frame was high.
  assign high_sum = high_cnt_q + (WIDTH+1)'(pwm_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      high_cnt_q  <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (!enable) begin
        state_q     <= S_IDLE;
        frame_cnt_q <= '0;
        high_cnt_q  <= '0;
        locked_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            frame_cnt_q <= '0;
            high_cnt_q  <= '0;
            locked_q    <= 1'b0;
            state_q     <= S_HUNT;
          end
          S_HUNT: begin
            if (rise) begin
              frame_cnt_q <= WIDTH'(1);
              high_cnt_q  <= (WIDTH+1)'(1);
              state_q     <= S_MEASURE;
            end
          end
          S_MEASURE: begin
            if (rise && frame_cnt_q != '0) begin
              // Edge off the frame grid: drop the partial frame and realign.
              err_q       <= 1'b1;
              locked_q    <= 1'b0;
              frame_cnt_q <= WIDTH'(1);
              high_cnt_q  <= (WIDTH+1)'(1);
            end else if (frame_cnt_q == CNT_MAX) begin
              sample_q    <= high_sum[WIDTH] ? CNT_MAX : high_sum[WIDTH-1:0];
              valid_q     <= 1'b1;
              err_q       <= high_sum[WIDTH];
              locked_q    <= 1'b1;
              frame_cnt_q <= '0;
              high_cnt_q  <= '0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
              high_cnt_q  <= high_sum;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Drives converter-style PWM frames into the demodulator and checks every
// cycle against a frame-window reference model, plus literal spot checks.
module tb_pwm_demodulator;

  localparam int W    = 8;
  localparam int PER  = 1 << W;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] sample_out;
  logic         sample_valid, locked, frame_err;

  int n_assert = 0;
  int n_fail   = 0;

  pwm_demodulator #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .locked       (locked),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers where the current frame started and sums the
  // delayed input over the last PER cycles when a frame completes.
  typedef enum {M_IDLE, M_HUNT, M_MEAS} mmode_e;
  mmode_e m_mode;
  logic   m_dl [SYNC];
  logic   m_sprev;
  bit     m_win [PER];
  int     m_n, m_start, m_sample;
  logic   m_valid, m_locked, m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC; i++) m_dl[i] = 1'b0;
      for (int i = 0; i < PER; i++) m_win[i] = 1'b0;
      m_sprev = 1'b0; m_mode = M_IDLE; m_n = 0; m_start = 0;
      m_sample = 0; m_valid = 1'b0; m_locked = 1'b0; m_err = 1'b0;
    end else begin
      logic s, r;
      int   pos, h;
      s = m_dl[SYNC-1];
      r = s & ~m_sprev;
      for (int i = SYNC-1; i > 0; i--) m_dl[i] = m_dl[i-1];
      m_dl[0] = pwm_in;
      m_sprev = s;
      m_win[m_n % PER] = s;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!enable) begin
        m_mode = M_IDLE; m_locked = 1'b0;
      end else begin
        case (m_mode)
          M_IDLE: m_mode = M_HUNT;
          M_HUNT: if (r) begin m_mode = M_MEAS; m_start = m_n; end
          default: begin
            pos = (m_n - m_start) % PER;
            if (r && pos != 0) begin
              m_err = 1'b1; m_locked = 1'b0; m_start = m_n;
            end else if (pos == PER-1) begin
              h = 0;
              for (int i = 0; i < PER; i++) h += int'(m_win[i]);
              m_sample = (h > PER-1) ? PER-1 : h;
              m_valid  = 1'b1;
              m_err    = (h == PER);
              m_locked = 1'b1;
            end
          end
        endcase
      end
      m_n++;
    end
  end

  always @(negedge clk) begin
    chk("sample_out",   int'(sample_out),   m_sample);
    chk("sample_valid", int'(sample_valid), int'(m_valid));
    chk("locked",       int'(locked),       int'(m_locked));
    chk("frame_err",    int'(frame_err),    int'(m_err));
  end

  // Pulse bookkeeping for the literal checks.
  int vcount = 0, ecount = 0, vlast = -1;
  always @(negedge clk) begin
    if (sample_valid) begin vcount <= vcount + 1; vlast <= int'(sample_out); end
    if (frame_err) ecount <= ecount + 1;
  end

  task automatic run_low(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1; pwm_in = 1'b0;
    end
  endtask

  // One converter frame: high while k < s (s = PER means stuck high).
  // exp >= 0 checks the one valid pulse (for the previous frame) seen here.
  task automatic run_frame(input int s, input int exp, input int dis_at = -1,
                           input int rst_at = -1);
    int v0 = vcount;
    for (int k = 0; k < PER; k++) begin
      @(posedge clk); #1;
      pwm_in = (k < s);
      if (k == dis_at) enable = 1'b0;
      if (k == rst_at) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_sample_async", int'(sample_out), 0);
        chk("rst_locked_async", int'(locked), 0);
      end
      if (rst_at >= 0 && k == rst_at + 10) rst = 1'b1;
      if (rst_at >= 0 && k == 200) enable = 1'b1;
    end
    if (exp >= 0) begin
      chk("frame_valid_count", vcount - v0, 1);
      chk("frame_sample", vlast, exp);
    end
  endtask

  initial begin
    int v0, e0;
    #40 rst = 1'b1;
    chk("reset_sample", int'(sample_out), 0);
    chk("reset_locked", int'(locked), 0);

    run_low(1000);
    chk("hunt_no_valid", vcount, 0);
    chk("hunt_locked", int'(locked), 0);

    run_frame(100, -1);
    run_frame(100, 100);
    run_frame(100, 100);
    run_frame(100, 100);
    chk("const_locked", int'(locked), 1);

    e0 = ecount;
    run_frame(0, 100);
    run_frame(1, 0);
    run_frame(255, 1);
    run_frame(100, 255);
    chk("extreme_locked", int'(locked), 1);
    chk("extreme_no_err", ecount - e0, 0);

    e0 = ecount;
    run_frame(PER, 100);
    run_frame(PER, 255);
    run_frame(PER, 255);
    run_frame(100, 255);
    run_frame(100, 100);
    chk("stuck_err_count", ecount - e0, 3);
    chk("stuck_locked", int'(locked), 1);

    e0 = ecount; v0 = vcount;
    run_low(37);
    run_frame(100, -1);
    chk("misalign_err", ecount - e0, 1);
    chk("misalign_valids", vcount - v0, 1);
    chk("misalign_unlocked", int'(locked), 0);
    run_frame(100, 100);
    chk("misalign_relock", int'(locked), 1);

    run_frame(100, 100, 128);
    v0 = vcount; e0 = ecount;
    run_frame(100, -1);
    chk("dis_no_valid", vcount - v0, 0);
    chk("dis_no_err", ecount - e0, 0);
    chk("dis_sample_held", int'(sample_out), 100);
    chk("dis_locked", int'(locked), 0);

    run_frame(100, -1, -1, 60);
    run_frame(77, -1);
    run_frame(77, 77);
    chk("rst_relock", int'(locked), 1);

    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 7) == 0) run_low($urandom_range(1, 200));
      run_frame($urandom_range(0, PER), -1,
                ($urandom_range(0, 12) == 0) ? $urandom_range(1, 254) : -1);
      enable = 1'b1;
    end
    run_low(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
